// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg - state encodings, parity constants and prescale helper shared by UART RX/TX
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Only 8, 16 and 32 clocks per bit are supported; anything else falls back to 8.
   function automatic int unsigned presc_clocks(input int unsigned presc);
      return (presc == 16 || presc == 32) ? presc : 32'd8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler - per-bit edge/bit counters and 3-sample majority vote
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_sampler #(
   parameter int PRESC_W   = 6,
   parameter int BIT_CNT_W = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [PRESC_W-1:0]   presc_i,
   input  logic                 start_i,
   input  logic                 run_i,
   input  logic                 rx_i,
   output logic                 sampled_bit_o,
   output logic                 vote_o,
   output logic                 sample_done_o,
   output logic                 resolve_o,
   output logic                 bit_end_o,
   output logic [BIT_CNT_W-1:0] bit_cnt_o
);

   localparam logic [PRESC_W-1:0] c_ONE = PRESC_W'(1);
   localparam logic [PRESC_W-1:0] c_TWO = PRESC_W'(2);

   logic [PRESC_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 s0_q, s1_q, sampled_bit_q;
   logic [PRESC_W-1:0]   w_half;
   logic                 w_s0_edge, w_s1_edge;

   assign w_half        = presc_i >> 1;
   assign w_s0_edge     = (edge_cnt_q == w_half - c_ONE);
   assign w_s1_edge     = (edge_cnt_q == w_half);
   assign sample_done_o = (edge_cnt_q == w_half + c_ONE);
   assign resolve_o     = (edge_cnt_q == w_half + c_TWO);
   assign bit_end_o     = (edge_cnt_q == presc_i - c_ONE);
   assign vote_o        = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
   assign sampled_bit_o = sampled_bit_q;
   assign bit_cnt_o     = bit_cnt_q;

   // The start-detect cycle is edge 0, so the counter enters the frame at 1.
   always_comb begin
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      if (!run_i) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (start_i) begin
         edge_cnt_d = c_ONE;
         bit_cnt_d  = '0;
      end else if (bit_end_o) begin
         edge_cnt_d = '0;
         bit_cnt_d  = bit_cnt_q + 1'b1;
      end else begin
         edge_cnt_d = edge_cnt_q + c_ONE;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         s0_q          <= 1'b1;
         s1_q          <= 1'b1;
         sampled_bit_q <= 1'b1;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         if (w_s0_edge)
            s0_q <= rx_i;
         if (w_s1_edge)
            s1_q <= rx_i;
         if (sample_done_o)
            sampled_bit_q <= vote_o;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - oversampling UART receiver: framing FSM, deserialiser, parity/stop checks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESC_W-1:0]    Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err
);

   localparam int                   BIT_CNT_W   = $clog2(DATA_WIDTH + 3);
   localparam logic [BIT_CNT_W-1:0] c_LAST_DATA = BIT_CNT_W'(DATA_WIDTH);

   uart_state_e           state_q, state_d;
   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_fail_q, par_fail_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic [PRESC_W-1:0]    w_presc_sel;
   logic                  w_sampled_bit, w_vote, w_sample_done, w_resolve, w_bit_end;
   logic [BIT_CNT_W-1:0]  w_bit_cnt;

   assign w_presc_sel = PRESC_W'(presc_clocks(32'(Prescale)));

   uart_rx_sampler #(
      .PRESC_W   (PRESC_W),
      .BIT_CNT_W (BIT_CNT_W)
   ) u_sampler (
      .CLK           (CLK),
      .RST           (RST),
      .presc_i       (presc_q),
      .start_i       (state_q == IDLE),
      .run_i         (state_d != IDLE),
      .rx_i          (RX_IN),
      .sampled_bit_o (w_sampled_bit),
      .vote_o        (w_vote),
      .sample_done_o (w_sample_done),
      .resolve_o     (w_resolve),
      .bit_end_o     (w_bit_end),
      .bit_cnt_o     (w_bit_cnt)
   );

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      shift_d      = shift_q;
      par_fail_d   = par_fail_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!RX_IN) begin
               state_d    = START;
               presc_d    = w_presc_sel;
               par_en_d   = PAR_EN;
               par_typ_d  = PAR_TYP;
               par_fail_d = 1'b0;
            end
         end
         START: begin
            if (w_resolve && w_sampled_bit)
               state_d = IDLE;
            else if (w_bit_end)
               state_d = DATA;
         end
         DATA: begin
            if (w_sample_done)
               shift_d = {w_vote, shift_q[DATA_WIDTH-1:1]};
            if (w_bit_end && w_bit_cnt == c_LAST_DATA)
               state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (w_sample_done)
               par_fail_d = (w_vote != ((^shift_q) ^ (par_typ_q == PAR_ODD)));
            if (w_bit_end)
               state_d = STOP;
         end
         STOP: begin
            // Outputs register on the sample edge so the pulses are visible in
            // the resolution cycle, when the FSM drops back to IDLE.
            if (w_sample_done) begin
               stp_err_d = ~w_vote;
               par_err_d = par_fail_q;
               if (w_vote && !par_fail_q) begin
                  data_valid_d = 1'b1;
                  p_data_d     = shift_q;
               end
            end
            if (w_resolve)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         presc_q      <= PRESC_W'(8);
         par_en_q     <= 1'b0;
         par_typ_q    <= PAR_EVEN;
         shift_q      <= '0;
         par_fail_q   <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         shift_q      <= shift_d;
         par_fail_q   <= par_fail_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign Data_Valid = data_valid_q;
   assign Par_Err    = par_err_q;
   assign Stp_Err    = stp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - scoreboard bench for uart_rx: directed frames, expected pulses queued
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;
   import uart_pkg::*;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          RX_IN = 1'b1;
   logic [PW-1:0] Prescale = 6'd8;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = PAR_EVEN;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid, Par_Err, Stp_Err;

   uart_rx #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .Par_Err    (Par_Err),
      .Stp_Err    (Stp_Err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       dv;
      logic       pe;
      logic       se;
      int         at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (RST && (Data_Valid || Par_Err || Stp_Err)) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b, expected none (cycle %0d)",
                     Data_Valid, Par_Err, Stp_Err, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("data_valid", 32'(Data_Valid), 32'(mon_e.dv));
            check("par_err",    32'(Par_Err),    32'(mon_e.pe));
            check("stp_err",    32'(Stp_Err),    32'(mon_e.se));
            check("p_data",     32'(P_DATA),     32'(mon_e.data));
            check("pulse_cycle", cyc,            mon_e.at);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Drives one frame from a negedge; abort_at >= 0 stops driving after that many cycles.
   task automatic send_frame(input logic [7:0] data, input int p, input logic pe, input logic ptyp,
                             input logic pbit, input logic stop,
                             input logic e_dv, input logic e_pe, input logic e_se,
                             input logic [7:0] e_data, input int abort_at, input bit perturb);
      logic [11:0] bits;
      int          n;
      exp_t        e;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = data[i];
      n = 9;
      if (pe) begin
         bits[n] = pbit;
         n++;
      end
      bits[n] = stop;
      n++;
      Prescale = PW'(p);
      PAR_EN   = pe;
      PAR_TYP  = ptyp;
      if (e_dv || e_pe || e_se) begin
         e.data = e_data;
         e.dv   = e_dv;
         e.pe   = e_pe;
         e.se   = e_se;
         e.at   = cyc + (n - 1) * p + p / 2 + 2;
         sb.push_back(e);
      end
      for (int c = 0; c < n * p; c++) begin
         if (abort_at >= 0 && c == abort_at) return;
         RX_IN = bits[c / p];
         if (perturb && c == 10) begin
            Prescale = 6'd16;
            PAR_EN   = 1'b1;
            PAR_TYP  = ~PAR_TYP;
         end
         @(negedge CLK);
      end
      RX_IN = 1'b1;
   endtask

   initial begin
      RST = 1'b0;
      idle(3);
      check("rst_p_data",     32'(P_DATA),      32'h0);
      check("rst_data_valid", 32'(Data_Valid),  32'h0);
      check("rst_par_err",    32'(Par_Err),     32'h0);
      check("rst_stp_err",    32'(Stp_Err),     32'h0);
      check("rst_state",      32'(dut.state_q), 32'(IDLE));
      RST = 1'b1;
      idle(4);

      // P=8, no parity, 0xA5: valid at +78
      send_frame(8'hA5, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, -1, 1'b0);
      idle(16);
      // P=16, even parity, 0x37 has five ones -> parity bit 1: valid at +170
      send_frame(8'h37, 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h37, -1, 1'b0);
      idle(16);
      // Same byte, wrong parity bit: Par_Err only, P_DATA keeps 0x37
      send_frame(8'h37, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h37, -1, 1'b0);
      idle(16);
      // Stop bit low on 0x3C: Stp_Err only at +78; trailing low is rejected as a glitch
      send_frame(8'h3C, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h37, -1, 1'b0);
      idle(32);
      check("state_after_stp_err", 32'(dut.state_q), 32'(IDLE));

      // Start glitch of 2 cycles at P=8
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      idle(2);
      RX_IN = 1'b1;
      idle(20);
      check("state_after_glitch", 32'(dut.state_q), 32'(IDLE));
      // 0x81 with config inputs disturbed mid-frame; latched P=8/no parity must hold
      send_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, -1, 1'b1);
      idle(16);

      // Back-to-back at P=32: pulses at +306 and +626
      send_frame(8'h55, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55, -1, 1'b0);
      send_frame(8'hAA, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, -1, 1'b0);
      idle(40);
      check("p_data_before_abort", 32'(P_DATA), 32'hAA);

      // Reset 40 cycles into a frame
      send_frame(8'hC3, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 40, 1'b0);
      RST = 1'b0;
      #1;
      check("abort_p_data",     32'(P_DATA),      32'h0);
      check("abort_data_valid", 32'(Data_Valid),  32'h0);
      check("abort_state",      32'(dut.state_q), 32'(IDLE));
      RX_IN = 1'b1;
      idle(2);
      RST = 1'b1;
      idle(4);
      send_frame(8'h0F, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F, -1, 1'b0);
      idle(16);

      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
